rtc_adj_sched: RTL and testbench

//  Schedules and arbitrates RTC adjustments (offset load, tick_inc update, clear) between the host register

---
 rtl/rtc_adj_sched_pkg.sv | 38 +++
 rtl/rtc_adj_sched_if.sv | 23 ++
 rtl/rtc_adj_rr_arb.sv | 39 +++
 rtl/rtc_adj_sched.sv | 200 ++++++++++++++++++++
 tb/tb_rtc_adj_sched.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_adj_sched_pkg.sv
// ----------------------------------------------------------------------------
// rtc_adj_sched_pkg
//   Shared definitions for the RTC adjustment scheduler: adjustment type
//   codes, scheduler FSM states, the request bundle and a validity helper.
// ----------------------------------------------------------------------------
package rtc_adj_sched_pkg;

  typedef enum logic [1:0] {
    ADJ_OFST = 2'b00,  // offset load (sc + ns)
    ADJ_TICK = 2'b01,  // tick increment update
    ADJ_CLR  = 2'b10,  // RTC clear
    ADJ_RSV  = 2'b11   // reserved, always rejected
  } adj_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_WAIT_WIN,
    ST_ISSUE,
    ST_SETTLE
  } sched_state_e;

  typedef struct packed {
    adj_type_e    typ;
    logic [47:0]  sc;
    logic [29:0]  ns;
    logic [31:0]  tick;
  } adj_req_t;

  localparam logic [29:0] NS_PER_SEC = 30'd1_000_000_000;
  localparam logic [31:0] NS_LAST    = 32'd999_999_999;

  // A request is rejected for the reserved type or an out-of-range ns field.
  function automatic logic req_valid(input adj_req_t r);
    return (r.typ != ADJ_RSV) && (r.ns < NS_PER_SEC);
  endfunction

endpackage

// File: rtl/rtc_adj_sched_if.sv
// ----------------------------------------------------------------------------
// rtc_adj_sched_if
//   One adjustment requester (host register path or servo).
//   req   level request, held until ack
//   typ   adjustment type
//   sc    seconds offset
//   ns    nanoseconds offset
//   tick  tick increment
//   ack   1-cycle: request consumed (accepted or rejected)
// ----------------------------------------------------------------------------
interface rtc_adj_sched_if;
  import rtc_adj_sched_pkg::*;

  logic        req;
  adj_type_e   typ;
  logic [47:0] sc;
  logic [29:0] ns;
  logic [31:0] tick;
  logic        ack;

  modport master (output req, typ, sc, ns, tick, input ack);
  modport slave  (input req, typ, sc, ns, tick, output ack);
endinterface

// File: rtl/rtc_adj_rr_arb.sv
// ----------------------------------------------------------------------------
// rtc_adj_rr_arb
//   Two-way round-robin arbiter with clear override. Index 0 = host,
//   index 1 = servo.
//   clk, rst   clock, async active-high reset
//   i_req      pending requests
//   i_clr      pending requests that are clears (subset of i_req)
//   i_adv      toggle the round-robin pointer (one per arbitration)
//   o_gnt      granted index
// ----------------------------------------------------------------------------
module rtc_adj_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic [1:0] i_clr,
  input  logic       i_adv,
  output logic       o_gnt
);

  logic r_ptr;  // side favoured on a non-clear tie; starts at host

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    o_gnt = 1'b0;
    if (i_clr[0])      o_gnt = 1'b0;     // host clear wins outright
    else if (i_clr[1]) o_gnt = 1'b1;
    else if (&i_req)   o_gnt = r_ptr;
    else               o_gnt = i_req[1];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ptr <= 1'b0;
    else if (i_adv) r_ptr <= ~r_ptr;
  end

endmodule

// File: rtl/rtc_adj_sched.sv
// ----------------------------------------------------------------------------
// rtc_adj_sched
//   Schedules RTC adjustments from the host and the servo. Offset loads and
//   clears are held off while rtc_ns_i is near the second rollover; one
//   adjustment in flight, followed by a settle period.
//   clk, rst         clock, async active-high reset
//   rtc_ns_i         current RTC ns field
//   host, srv        requester interfaces (slave side)
//   rtc_ofst_sc_o    offset seconds (holds last issued value)
//   rtc_ofst_ns_o    offset ns (holds last issued value)
//   rtc_tick_inc_o   tick increment (persistent)
//   rtc_load_o       1-cycle offset-load strobe
//   rtc_clear_o      1-cycle clear strobe
//   busy_o           scheduler not idle
//   err_o            1-cycle: request rejected
//   forced_o         sticky: a load was issued on wait timeout
// ----------------------------------------------------------------------------
module rtc_adj_sched
  import rtc_adj_sched_pkg::*;
#(
  parameter logic [31:0] GUARD_NS     = 32'd1000,
  parameter logic [7:0]  SETTLE_CYC   = 8'd8,
  parameter logic [15:0] WAIT_MAX     = 16'd4096,
  parameter logic [31:0] TICK_INC_RST = 32'h1999_999a
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [29:0]    rtc_ns_i,
  rtc_adj_sched_if.slave host,
  rtc_adj_sched_if.slave srv,
  output logic [47:0]    rtc_ofst_sc_o,
  output logic [29:0]    rtc_ofst_ns_o,
  output logic [31:0]    rtc_tick_inc_o,
  output logic           rtc_load_o,
  output logic           rtc_clear_o,
  output logic           busy_o,
  output logic           err_o,
  output logic           forced_o
);

  sched_state_e r_state;
  logic         r_gnt;
  adj_type_e    r_hold_typ;
  logic [47:0]  r_hold_sc;
  logic [29:0]  r_hold_ns;
  logic [15:0]  r_wait_cnt;
  logic [7:0]   r_settle_cnt;
  logic         r_host_ack, r_srv_ack;
  logic [47:0]  r_ofst_sc;
  logic [29:0]  r_ofst_ns;
  logic [31:0]  r_tick_inc;
  logic         r_load, r_clear, r_busy, r_err, r_forced;

  logic [1:0]   w_req, w_clr;
  logic         w_gnt, w_adv, w_safe;
  logic [31:0]  w_ns_ext;
  adj_req_t     w_cand;

  // A requester whose ack is on the wire this cycle still shows req (it only
  // sees ack at this edge); mask it so IDLE does not re-arbitrate it.
  assign w_req = {srv.req & ~r_srv_ack, host.req & ~r_host_ack};
  assign w_clr = w_req & {srv.typ == ADJ_CLR, host.typ == ADJ_CLR};
  assign w_adv = (r_state == ST_ARB) && (|w_req);

  rtc_adj_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .i_clr (w_clr),
    .i_adv (w_adv),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_cand = '{typ: host.typ, sc: host.sc, ns: host.ns, tick: host.tick};
    if (w_gnt) w_cand = '{typ: srv.typ, sc: srv.sc, ns: srv.ns, tick: srv.tick};
  end

  // Safe window keeps offset loads clear of the ns wrap on both sides.
  assign w_ns_ext = {2'b00, rtc_ns_i};
  assign w_safe   = (w_ns_ext >= GUARD_NS) && (w_ns_ext < (NS_LAST - GUARD_NS));

  // NOTE: every register, holding regs included, is reset so nothing
  // downstream ever observes X after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= 1'b0;
      r_hold_typ   <= ADJ_OFST;
      r_hold_sc    <= '0;
      r_hold_ns    <= '0;
      r_wait_cnt   <= '0;
      r_settle_cnt <= '0;
      r_host_ack   <= 1'b0;
      r_srv_ack    <= 1'b0;
      r_ofst_sc    <= '0;
      r_ofst_ns    <= '0;
      r_tick_inc   <= TICK_INC_RST;
      r_load       <= 1'b0;
      r_clear      <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_forced     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      r_host_ack <= 1'b0;
      r_srv_ack  <= 1'b0;
      r_load     <= 1'b0;
      r_clear    <= 1'b0;
      r_err      <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_state <= ST_ARB;
            r_busy  <= 1'b1;
          end
        end

        ST_ARB: begin
          if (!(|w_req)) begin
            // Request withdrawn before arbitration: never served.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gnt      <= w_gnt;
            r_hold_typ <= w_cand.typ;
            r_hold_sc  <= w_cand.sc;
            r_hold_ns  <= w_cand.ns;
            if (!req_valid(w_cand)) begin
              r_host_ack <= ~w_gnt;
              r_srv_ack  <= w_gnt;
              r_err      <= 1'b1;
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
            end else if (w_cand.typ == ADJ_TICK) begin
              // Tick updates cannot race the wrap; issue straight away.
              r_host_ack <= ~w_gnt;
              r_srv_ack  <= w_gnt;
              r_tick_inc <= w_cand.tick;
              r_state    <= ST_ISSUE;
            end else begin
              r_wait_cnt <= '0;
              r_state    <= ST_WAIT_WIN;
            end
          end
        end

        ST_WAIT_WIN: begin
          if (w_safe || (r_wait_cnt == WAIT_MAX)) begin
            if (!w_safe) r_forced <= 1'b1;
            r_host_ack <= ~r_gnt;
            r_srv_ack  <= r_gnt;
            if (r_hold_typ == ADJ_OFST) begin
              r_ofst_sc <= r_hold_sc;
              r_ofst_ns <= r_hold_ns;
              r_load    <= 1'b1;
            end else begin
              r_clear   <= 1'b1;
            end
            r_state <= ST_ISSUE;
          end else if (r_wait_cnt != 16'hFFFF) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end

        ST_ISSUE: begin
          r_settle_cnt <= SETTLE_CYC - 8'd1;
          r_state      <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (r_settle_cnt == 8'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign host.ack       = r_host_ack;
  assign srv.ack        = r_srv_ack;
  assign rtc_ofst_sc_o  = r_ofst_sc;
  assign rtc_ofst_ns_o  = r_ofst_ns;
  assign rtc_tick_inc_o = r_tick_inc;
  assign rtc_load_o     = r_load;
  assign rtc_clear_o    = r_clear;
  assign busy_o         = r_busy;
  assign err_o          = r_err;
  assign forced_o       = r_forced;

endmodule

// File: tb/tb_rtc_adj_sched.sv
// ----------------------------------------------------------------------------
// tb_rtc_adj_sched
//   Directed scenarios plus randomized requests for rtc_adj_sched, checked
//   against a transaction-level reference model of the scheduling rules.
// ----------------------------------------------------------------------------
module tb_rtc_adj_sched;
  import rtc_adj_sched_pkg::*;

  localparam logic [31:0] GUARD    = 32'd1000;
  localparam logic [7:0]  SETTLE   = 8'd8;
  localparam logic [15:0] WMAX     = 16'd4096;
  localparam logic [31:0] TICK_RST = 32'h1999_999a;
  localparam int          NS_SEC   = 1_000_000_000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] rtc_ns;
  logic [47:0] ofst_sc;
  logic [29:0] ofst_ns;
  logic [31:0] tick_inc;
  logic        load, clear, busy, err, forced;

  rtc_adj_sched_if host_if ();
  rtc_adj_sched_if srv_if ();

  rtc_adj_sched #(
    .GUARD_NS     (GUARD),
    .SETTLE_CYC   (SETTLE),
    .WAIT_MAX     (WMAX),
    .TICK_INC_RST (TICK_RST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rtc_ns_i       (rtc_ns),
    .host           (host_if),
    .srv            (srv_if),
    .rtc_ofst_sc_o  (ofst_sc),
    .rtc_ofst_ns_o  (ofst_ns),
    .rtc_tick_inc_o (tick_inc),
    .rtc_load_o     (load),
    .rtc_clear_o    (clear),
    .busy_o         (busy),
    .err_o          (err),
    .forced_o       (forced)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC ns source: either held at ns_hold or free-running in 100 ns steps.
  logic        ns_run  = 1'b0;
  logic [29:0] ns_hold = '0;
  logic [29:0] ns_tick = '0;
  assign rtc_ns = ns_run ? ns_tick : ns_hold;

  initial forever begin
    int nx;
    @(posedge clk);
    #1;
    if (ns_run) begin
      nx = int'(ns_tick) + 100;
      if (nx >= NS_SEC) nx = nx - NS_SEC;
      ns_tick = 30'(nx);
    end else begin
      ns_tick = ns_hold;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [47:0] m_sc;
  logic [29:0] m_ns;
  logic [31:0] m_tick;
  bit          m_forced;
  bit          m_ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_safe(input int ns);
    return (ns >= int'(GUARD)) && (ns < 999_999_999 - int'(GUARD));
  endfunction

  function automatic adj_type_e rnd_type();
    logic [1:0] v;
    v = 2'($urandom_range(0, 3));
    return adj_type_e'(v);
  endfunction

  task automatic model_reset();
    m_sc = '0; m_ns = '0; m_tick = TICK_RST; m_forced = 1'b0; m_ptr = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {host_if.ack, srv_if.ack, load, clear, err}, 5'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ofst_sc"}, ofst_sc, 48'h0);
    check({tag, "_ofst_ns"}, ofst_ns, 30'h0);
    check({tag, "_tick"}, tick_inc, TICK_RST);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_forced"}, forced, 1'b0);
    check_quiet({tag, "_strobes"});
  endtask

  task automatic set_req(input bit side, input adj_type_e t, input logic [47:0] sc,
                         input logic [29:0] ns, input logic [31:0] tk);
    if (!side) begin
      host_if.typ = t; host_if.sc = sc; host_if.ns = ns; host_if.tick = tk; host_if.req = 1'b1;
    end else begin
      srv_if.typ = t; srv_if.sc = sc; srv_if.ns = ns; srv_if.tick = tk; srv_if.req = 1'b1;
    end
  endtask

  // Serve every request currently raised (called on the negedge the requests
  // were raised). Grant order, ack cycle and outputs come from the model.
  task automatic serve();
    bit          pend_h, pend_s, win, bad, fz;
    adj_type_e   t;
    logic [47:0] sc;
    logic [29:0] ns;
    logic [31:0] tk;
    int          idle_from, arb_c, exp_ack;
    idle_from = cyc;
    pend_h = host_if.req;
    pend_s = srv_if.req;
    while (pend_h || pend_s) begin
      if (pend_h && host_if.typ == ADJ_CLR)     win = 1'b0;
      else if (pend_s && srv_if.typ == ADJ_CLR) win = 1'b1;
      else if (pend_h && pend_s)                win = m_ptr;
      else                                      win = pend_s;
      m_ptr = ~m_ptr;
      if (!win) begin t = host_if.typ; sc = host_if.sc; ns = host_if.ns; tk = host_if.tick; end
      else      begin t = srv_if.typ;  sc = srv_if.sc;  ns = srv_if.ns;  tk = srv_if.tick;  end
      bad   = (t == ADJ_RSV) || (int'(ns) >= NS_SEC);
      arb_c = idle_from + 1;
      fz    = 1'b0;
      exp_ack = (bad || t == ADJ_TICK) ? arb_c + 1 : -1;
      forever begin
        @(negedge clk);
        if (exp_ack < 0 && cyc > arb_c) begin
          if (is_safe(int'(rtc_ns))) exp_ack = cyc + 1;
          else if (cyc - arb_c - 1 == int'(WMAX)) begin exp_ack = cyc + 1; fz = 1'b1; end
        end
        if (cyc == exp_ack) break;
        if (cyc > idle_from + int'(WMAX) + 16) begin
          n_checks++;
          n_errors++;
          $error("FAIL ack_timeout: no ack by cycle %0d", cyc);
          host_if.req = 1'b0;
          srv_if.req  = 1'b0;
          return;
        end
        check_quiet("early_strobe");
      end
      check("host_ack", host_if.ack, !win);
      check("srv_ack", srv_if.ack, win);
      check("err", err, bad);
      check("load", load, !bad && t == ADJ_OFST);
      check("clear", clear, !bad && t == ADJ_CLR);
      check("busy_at_ack", busy, !bad);
      if (!bad) begin
        if (t == ADJ_OFST) begin m_sc = sc; m_ns = ns; end
        if (t == ADJ_TICK) m_tick = tk;
        m_forced = m_forced | fz;
      end
      check("ofst_sc", ofst_sc, m_sc);
      check("ofst_ns", ofst_ns, m_ns);
      check("tick_inc", tick_inc, m_tick);
      check("forced", forced, m_forced);
      if (!win) begin host_if.req = 1'b0; pend_h = 1'b0; end
      else      begin srv_if.req  = 1'b0; pend_s = 1'b0; end
      idle_from = bad ? exp_ack : exp_ack + int'(SETTLE) + 1;
    end
    while (cyc <= idle_from) begin
      @(negedge clk);
      check_quiet("settle_strobe");
      if (cyc == idle_from - 1) check("busy_settle", busy, 1'b1);
    end
    check("busy_idle", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    host_if.req = 1'b0;
    srv_if.req  = 1'b0;
    @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    host_if.req = 1'b0; host_if.typ = ADJ_OFST; host_if.sc = '0; host_if.ns = '0; host_if.tick = '0;
    srv_if.req  = 1'b0; srv_if.typ  = ADJ_OFST; srv_if.sc  = '0; srv_if.ns  = '0; srv_if.tick  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;
    @(negedge clk);

    // 1: host offset in the safe window
    ns_hold = 30'd500_000_000;
    @(negedge clk);
    set_req(1'b0, ADJ_OFST, 48'h1234_5678, 30'h3000_0000, 32'h0);
    serve();

    // 2: offset raised just before the wrap, rtc_ns running
    ns_hold = 30'd999_999_500;
    repeat (2) @(negedge clk);
    ns_run = 1'b1;
    set_req(1'b0, ADJ_OFST, 48'h0000_ABCD_0001, 30'($urandom_range(0, NS_SEC - 1)), 32'h0);
    serve();
    ns_run = 1'b0;

    // 3: rtc_ns frozen at the top of the second -> forced load
    ns_hold = 30'd999_999_999;
    @(negedge clk);
    set_req(1'b1, ADJ_OFST, 48'h0000_0000_0042, 30'd123_456_789, 32'h0);
    serve();
    ns_hold = 30'd500_000_000;
    @(negedge clk);
    set_req(1'b0, ADJ_TICK, 48'h0, 30'h0, 32'h1234_5678);
    serve();
    do_reset();

    // 4: host and servo tick updates together
    set_req(1'b0, ADJ_TICK, 48'h0, 30'h0, 32'hAAAA_0001);
    set_req(1'b1, ADJ_TICK, 48'h0, 30'h0, 32'h5555_0002);
    serve();
    check("t4_tick_final", tick_inc, 32'h5555_0002);

    // 5: host clear beats servo offset; then an out-of-range ns is rejected
    set_req(1'b0, ADJ_CLR, 48'h0, 30'h0, 32'h0);
    set_req(1'b1, ADJ_OFST, 48'h0000_0777_0000, 30'd999_999_998, 32'h0);
    serve();
    set_req(1'b0, ADJ_OFST, 48'h1, 30'h3B9A_CA00, 32'h0);
    serve();

    // Randomized requests, single and contending
    for (int i = 0; i < 40; i++) begin
      int sel;
      ns_hold = 30'($urandom_range(int'(GUARD), 999_999_998 - int'(GUARD)));
      sel = int'($urandom_range(1, 3));
      for (int s = 0; s < 2; s++) begin
        if (sel[s]) begin
          logic [29:0] rns;
          if ($urandom_range(0, 3) == 0) rns = 30'($urandom_range(NS_SEC, 32'h3FFF_FFFF));
          else                           rns = 30'($urandom_range(0, NS_SEC - 1));
          set_req(s[0], rnd_type(), 48'({$urandom(), $urandom()}), rns, $urandom());
        end
      end
      serve();
    end

    // 6: reset while waiting for the window
    ns_hold = 30'd999_999_999;
    @(negedge clk);
    set_req(1'b0, ADJ_OFST, 48'h0000_0000_0099, 30'd1, 32'h0);
    repeat (6) begin
      @(negedge clk);
      check_quiet("t6_wait");
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("t6_rst");
    @(negedge clk);
    host_if.req = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_quiet("t6_after");
    check("t6_busy", busy, 1'b0);
    check("t6_tick", tick_inc, TICK_RST);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
